// File: rtl/switch_debounce.sv
`timescale 1ns/1ps
// switch_debounce: two-flop synchronizer plus a whole-vector stability counter for the board switches.
// Define SWITCH_CHANGE_IRQ_EN to build the sticky sw_irq change flag, which a switch read clears.
module switch_debounce #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch_raw,
    input  logic             ior,
    input  logic             switchctrl,
    output logic [WIDTH-1:0] ioread_data_switch,
    output logic             sw_valid,
    output logic             sw_changed,
    output logic             sw_irq
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync2_bits;
    logic [WIDTH-1:0] cand_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             valid_reg;
    logic             changed_reg;

    // Each pin is an independent asynchronous source, so each gets its own flop pair.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= switch_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            assign sync2_bits[gi] = sync2_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_reg    <= '0;
            cnt_reg     <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= 1'b0;
            if (sync2_bits != cand_reg) begin
                cand_reg <= sync2_bits;
                cnt_reg  <= '0;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                // Counter saturates here; recommitting an unchanged value is a no-op.
                data_reg    <= cand_reg;
                valid_reg   <= 1'b1;
                changed_reg <= (cand_reg != data_reg);
            end
        end
    end

    assign ioread_data_switch = data_reg;
    assign sw_valid           = valid_reg;
    assign sw_changed         = changed_reg;

`ifdef SWITCH_CHANGE_IRQ_EN
    logic irq_reg;

    // Set has priority over the read-clear so a change landing during a read is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else if (changed_reg) begin
            irq_reg <= 1'b1;
        end else if (ior && switchctrl) begin
            irq_reg <= 1'b0;
        end
    end

    assign sw_irq = irq_reg;
`else
    logic unused_read_strobe;

    assign unused_read_strobe = ior ^ switchctrl;
    assign sw_irq             = 1'b0;
`endif

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Upstream feeder of the IO read path: conditions the 16 raw board switches into a clean, stable vector on ioread_data_switch, which the IO read stage returns to memorio on a switch read.
- Two-flop synchronizer, then a whole-vector stability counter; a new value commits only after it has held steady for DEBOUNCE_CYCLES consecutive clocks.
- Also provides status: a valid flag and a one-cycle change pulse.

Parameters:
- WIDTH, 16, number of switch bits.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before commit (10 ms at 100 MHz). Legal range is 1 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- switch_raw  input  WIDTH  asynchronous switch pins.
- ior  input  1  read strobe from the controller.
- switchctrl  input  1  switch chip-select from memorio.
- ioread_data_switch  output  WIDTH  debounced switch vector.
- sw_valid  output  1  high once the first value has committed after reset.
- sw_changed  output  1  one-cycle pulse when the committed value changes.
- sw_irq  output  1  sticky change flag; live only with the optional feature.

Behaviour:
- Reset is sampled on the clk edge. On that edge, clear to 0: sync1, sync2, cand, cnt, ioread_data_switch, sw_valid, sw_changed and sw_irq.
- Reset asserted mid-count aborts the count. It dominates every other event in the same cycle.
- Synchronizer: sync1 <= switch_raw; sync2 <= sync1. No logic between the two stages.
- Each cycle, evaluate in priority order:
  - sync2 != cand: cand <= sync2; cnt <= 0. Any single-bit bounce restarts the whole-vector count.
  - sync2 == cand and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 == cand and cnt == DEBOUNCE_CYCLES-1 (commit): ioread_data_switch <= cand; sw_valid <= 1. cnt holds, so it saturates and never wraps.
- Commit also repeats every cycle while the input stays stable. This is harmless because the value is unchanged.
- sw_changed is high for exactly the cycle after a commit edge where cand != the previous ioread_data_switch; otherwise it is 0.
  - The first commit after reset pulses only if cand is nonzero.
- Latency: a switch_raw value settled before edge E0 and held appears on ioread_data_switch after edge E0+DEBOUNCE_CYCLES+2.
- Input changes during counting:
  - An input that returns to the old committed value before commit yields no commit change and no pulse.
  - With DEBOUNCE_CYCLES=1, a value commits after 1 stable cycle.
- Outputs are registered. No combinational path from switch_raw, ior or switchctrl to any output.

Optional Feature:
- Macro: SWITCH_CHANGE_IRQ_EN.
- Defined:
  - sw_irq sets to 1 on any cycle sw_changed is 1.
  - sw_irq clears on a cycle with ior & switchctrl high.
  - If set and clear occur in the same cycle, set wins, so no change is lost.
- Undefined: sw_irq is constant 0; ior and switchctrl are ignored; no extra flops are generated.

Test Plan:
- Reset: DEBOUNCE_CYCLES=4, switch_raw=16'hFFFF held through reset → all outputs 0 while reset=1. After release, ioread_data_switch=16'hFFFF exactly 6 edges later, with sw_valid=1 and a 1-cycle sw_changed.
- Clean change: stable 16'h0000, switch_raw→16'h00A5 before edge E0 → output unchanged through E0+5; 16'h00A5 after E0+6; sw_changed high for 1 cycle only.
- Bounce: toggle bit 3 every 2 cycles for 20 cycles, then hold 16'h0008 → no output change during bouncing; 16'h0008 commits exactly 6 edges after the last toggle.
- Glitch reject: committed 16'h1234; 16'h1235 for 3 cycles, then back to 16'h1234 → output stays 16'h1234; sw_changed never asserts.
- Reset mid-count: raw→16'hBEEF, reset pulsed 1 cycle at count 2 → output 0, sw_valid 0; 16'hBEEF commits 6 edges after reset release.
- IRQ (SWITCH_CHANGE_IRQ_EN defined): commit 16'h0001 → sw_irq=1 and stays 1. ior=switchctrl=1 for 1 cycle → sw_irq=0. Set and clear in the same cycle → sw_irq=1. Macro undefined → sw_irq always 0.
